// File: rtl/rtc_pkg.sv
// Shared widths, limits and time record for the RTC timekeeper.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: none.
package rtc_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX   = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX   = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX    = 5'd23;
    localparam logic [HR_W-1:0]  HR12_NOON = 5'd12;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } time_t;

    // 24-hour value to displayed value; midnight shows as 12 in 12-hour mode.
    function automatic logic [HR_W-1:0] disp_hr(input logic [HR_W-1:0] h, input logic m12);
        if (!m12)
            return h;
        if (h == '0)
            return HR12_NOON;
        if (h > HR12_NOON)
            return h - HR12_NOON;
        return h;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load; load beats increment.
// Latency: count updates on the edge after inc/load; carry_out is combinational.
// Backpressure: none.
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         carry_out
);

    logic at_max;

    assign at_max    = (count == W'(MAX));
    assign carry_out = inc && !load && at_max;

    always_comb begin
        count_nxt = count;
        if (load)
            count_nxt = load_val;
        else if (inc)
            count_nxt = at_max ? '0 : count + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// 24-hour hh:mm:ss timekeeper with 1 Hz prescaler, hold, validated load, 12/24 h display.
// Latency: outputs registered, 1 cycle after tick/load; optional alarm via RTC_TIMEKEEPER_ALARM_EN.
// Backpressure: none; a load request is accepted or rejected (set_err) in one cycle.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             mode_12h,
    input  logic             set_valid,
    input  logic [SEC_W-1:0] set_sec,
    input  logic [MIN_W-1:0] set_min,
    input  logic [HR_W-1:0]  set_hr,
    input  logic             alarm_arm,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic [HR_W-1:0]  alarm_hr,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic [HR_W-1:0]  hr_disp,
    output logic             pm,
    output logic             sec_tick,
    output logic             set_err,
    output logic             alarm
);

    logic [DIV_W-1:0] presc;
    logic             tick;
    logic             set_ok;
    logic             load;
    logic             adv;
    logic             sec_carry;
    logic             min_carry;
    logic             hr_carry_unused;
    time_t            nxt;

    assign tick   = !hold && (presc == DIV_W'(TICK_DIV - 1));
    assign set_ok = (set_sec <= SEC_MAX) && (set_min <= MIN_MAX) && (set_hr <= HR_MAX);
    assign load   = set_valid && set_ok;
    assign adv    = tick && !load;

    // An accepted load restarts the second so the next tick is a full period away.
    always_ff @(posedge clk) begin
        if (reset)
            presc <= '0;
        else if (load || tick)
            presc <= '0;
        else if (!hold)
            presc <= presc + DIV_W'(1);
    end

    mod_counter #(.W(SEC_W), .MAX(int'(SEC_MAX))) u_sec (
        .clk(clk), .reset(reset), .inc(adv), .load(load), .load_val(set_sec),
        .count(sec), .count_nxt(nxt.sec), .carry_out(sec_carry)
    );

    mod_counter #(.W(MIN_W), .MAX(int'(MIN_MAX))) u_min (
        .clk(clk), .reset(reset), .inc(sec_carry), .load(load), .load_val(set_min),
        .count(min), .count_nxt(nxt.min), .carry_out(min_carry)
    );

    mod_counter #(.W(HR_W), .MAX(int'(HR_MAX))) u_hr (
        .clk(clk), .reset(reset), .inc(min_carry), .load(load), .load_val(set_hr),
        .count(hr), .count_nxt(nxt.hr), .carry_out(hr_carry_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hr_disp  <= mode_12h ? HR12_NOON : '0;
            pm       <= 1'b0;
            sec_tick <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            hr_disp  <= disp_hr(nxt.hr, mode_12h);
            pm       <= (nxt.hr >= HR12_NOON);
            sec_tick <= adv;
            set_err  <= set_valid && !set_ok;
        end
    end

`ifdef RTC_TIMEKEEPER_ALARM_EN
    // Only a tick can fire; nxt is always in range so bad alarm values never match.
    always_ff @(posedge clk) begin
        if (reset)
            alarm <= 1'b0;
        else
            alarm <= adv && alarm_arm && (nxt.sec == '0) &&
                     (nxt.min == alarm_min) && (nxt.hr == alarm_hr);
    end
`else
    logic unused_alarm_in;
    assign unused_alarm_in = ^{alarm_arm, alarm_min, alarm_hr};
    assign alarm = 1'b0;
`endif

endmodule
